// File: rtl/ring_pos_to_remote_scheduler.sv
// rtl/ring_pos_to_remote_scheduler.sv - round-robin packetiser of remote position buffers onto the TX stream
module ring_pos_to_remote_scheduler #(
    parameter int NUM_REMOTE_DEST_NODES = 4,
    parameter int REMOTE_NODE_IDX_WIDTH = 2,
    parameter int CNT_WIDTH             = 8,
    parameter int BURST_LEN             = 8,
    parameter int LEN_WIDTH             = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       i_iter_done,
    input  logic [NUM_REMOTE_DEST_NODES*CNT_WIDTH-1:0] i_buf_count,
    output logic [NUM_REMOTE_DEST_NODES-1:0]           o_buf_rd_en,
    output logic [REMOTE_NODE_IDX_WIDTH-1:0]           o_buf_sel,
    output logic                                       o_tx_valid,
    input  logic                                       i_tx_ready,
    output logic                                       o_tx_is_header,
    output logic                                       o_tx_last,
    output logic [REMOTE_NODE_IDX_WIDTH-1:0]           o_tx_dest,
    output logic [LEN_WIDTH-1:0]                       o_tx_len,
    output logic                                       o_busy,
    output logic                                       o_flush_done
);

    localparam int N  = NUM_REMOTE_DEST_NODES;
    localparam int IW = REMOTE_NODE_IDX_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_t;

    state_t                 state, state_nxt;
    logic [IW-1:0]          ptr, dest, dest_inc, grant_idx;
    logic [LEN_WIDTH-1:0]   len, remaining, grant_len;
    logic                   flush_pending, flush_done_q;
    logic [N-1:0]           req;
    logic                   any_nonzero, grant_found, flush_finish;
    logic [CNT_WIDTH-1:0]   count [N];
    logic [CNT_WIDTH-1:0]   grant_count;
    logic [IW:0]            scan;

    always_comb begin
        any_nonzero = 1'b0;
        for (int d = 0; d < N; d++) begin
            count[d]    = i_buf_count[d*CNT_WIDTH +: CNT_WIDTH];
            req[d]      = (count[d] >= CNT_WIDTH'(BURST_LEN)) | (flush_pending & (count[d] != '0));
            any_nonzero = any_nonzero | (count[d] != '0);
        end
    end

    // Scan upward from the priority pointer with wrap-around; first requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int i = 0; i < N; i++) begin
            scan = {1'b0, ptr} + (IW+1)'(i);
            if (scan >= (IW+1)'(N))
                scan = scan - (IW+1)'(N);
            if (!grant_found && req[scan[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[IW-1:0];
            end
        end
    end

    assign grant_count  = count[grant_idx];
    assign grant_len    = (grant_count >= CNT_WIDTH'(BURST_LEN)) ? LEN_WIDTH'(BURST_LEN)
                                                                 : grant_count[LEN_WIDTH-1:0];
    assign dest_inc     = (dest == IW'(N-1)) ? '0 : dest + IW'(1);
    assign flush_finish = (state == ST_IDLE) && flush_pending && !any_nonzero;
    assign o_busy       = (state != ST_IDLE) | flush_pending;
    assign o_flush_done = flush_done_q;

    always_comb begin
        state_nxt      = state;
        o_buf_rd_en    = '0;
        o_buf_sel      = '0;
        o_tx_valid     = 1'b0;
        o_tx_is_header = 1'b0;
        o_tx_last      = 1'b0;
        o_tx_dest      = '0;
        o_tx_len       = '0;
        case (state)
            ST_IDLE: begin
                if (grant_found)
                    state_nxt = ST_HDR;
            end
            ST_HDR: begin
                o_tx_valid     = 1'b1;
                o_tx_is_header = 1'b1;
                o_tx_dest      = dest;
                o_tx_len       = len;
                if (i_tx_ready)
                    state_nxt = ST_DATA;
            end
            ST_DATA: begin
                o_tx_valid  = 1'b1;
                o_tx_dest   = dest;
                o_tx_len    = len;
                o_buf_sel   = dest;
                o_buf_rd_en = i_tx_ready ? (N'(1) << dest) : '0;
                o_tx_last   = (remaining == LEN_WIDTH'(1));
                if (i_tx_ready && remaining == LEN_WIDTH'(1))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A reset cycle abandons the packet without popping or presenting a flit.
        if (rst) begin
            o_buf_rd_en = '0;
            o_tx_valid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            dest          <= '0;
            len           <= '0;
            remaining     <= '0;
            flush_pending <= 1'b0;
            flush_done_q  <= 1'b0;
        end else begin
            state        <= state_nxt;
            flush_done_q <= flush_finish;
            if (i_iter_done)
                flush_pending <= 1'b1;
            else if (flush_finish)
                flush_pending <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        dest <= grant_idx;
                        len  <= grant_len;
                    end
                end
                ST_HDR: begin
                    if (i_tx_ready)
                        remaining <= len;
                end
                ST_DATA: begin
                    if (i_tx_ready) begin
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1))
                            ptr <= dest_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_pos_to_remote_scheduler.sv
// tb/tb_ring_pos_to_remote_scheduler.sv - scoreboard bench for ring_pos_to_remote_scheduler
module tb_ring_pos_to_remote_scheduler;

    localparam int N  = 4;
    localparam int CW = 8;

    typedef struct packed {
        logic       hdr;
        logic       last;
        logic [1:0] dest;
        logic [3:0] len;
    } flit_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_iter_done;
    logic [N*CW-1:0] i_buf_count;
    logic [N-1:0]  o_buf_rd_en;
    logic [1:0]    o_buf_sel;
    logic          o_tx_valid;
    logic          i_tx_ready;
    logic          o_tx_is_header;
    logic          o_tx_last;
    logic [1:0]    o_tx_dest;
    logic [3:0]    o_tx_len;
    logic          o_busy;
    logic          o_flush_done;

    int    checks = 0;
    int    failures = 0;
    int    cnt [N];
    int    cyc;
    int    pops;
    int    fd_q [$];
    flit_t exp_q [$];
    logic  prev_stall = 1'b0;

    ring_pos_to_remote_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .i_iter_done   (i_iter_done),
        .i_buf_count   (i_buf_count),
        .o_buf_rd_en   (o_buf_rd_en),
        .o_buf_sel     (o_buf_sel),
        .o_tx_valid    (o_tx_valid),
        .i_tx_ready    (i_tx_ready),
        .o_tx_is_header(o_tx_is_header),
        .o_tx_last     (o_tx_last),
        .o_tx_dest     (o_tx_dest),
        .o_tx_len      (o_tx_len),
        .o_busy        (o_busy),
        .o_flush_done  (o_flush_done)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] all_outs();
        return {o_buf_rd_en, o_buf_sel, o_tx_valid, o_tx_is_header, o_tx_last,
                o_tx_dest, o_tx_len, o_busy, o_flush_done};
    endfunction

    task automatic drive_counts();
        for (int d = 0; d < N; d++)
            i_buf_count[d*CW +: CW] = CW'(cnt[d]);
    endtask

    task automatic push_pkt(input int dest, input int len);
        flit_t f;
        f.hdr = 1'b1; f.last = 1'b0; f.dest = 2'(dest); f.len = 4'(len);
        exp_q.push_back(f);
        for (int k = 1; k <= len; k++) begin
            f.hdr  = 1'b0;
            f.last = (k == len);
            exp_q.push_back(f);
        end
    endtask

    // One clock: drive inputs, sample outputs mid-cycle, update the buffer model on the edge.
    task automatic tick(input logic iter, input logic rdy);
        flit_t       e;
        logic [13:0] obs, expv;
        i_iter_done = iter;
        i_tx_ready  = rdy;
        #1;
        cyc++;
        if (o_flush_done) fd_q.push_back(cyc);
        if (rst) begin
            check("rst_no_pop", 64'(o_buf_rd_en), 64'(0));
            check("rst_no_valid", 64'(o_tx_valid), 64'(0));
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("valid_held", 64'(o_tx_valid), 64'(1));
            if (o_tx_valid) begin
                check("sb_has_entry", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e    = exp_q[0];
                    expv = {e.hdr, e.last, e.dest, e.len, (e.hdr ? 2'd0 : e.dest),
                            ((!e.hdr && rdy) ? (4'(1) << e.dest) : 4'(0))};
                    obs  = {o_tx_is_header, o_tx_last, o_tx_dest, o_tx_len, o_buf_sel, o_buf_rd_en};
                    check("flit", 64'(obs), 64'(expv));
                    if (rdy) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_no_pop", 64'(o_buf_rd_en), 64'(0));
            end
            prev_stall = o_tx_valid && !rdy;
        end
        for (int d = 0; d < N; d++)
            if (o_buf_rd_en[d]) begin
                cnt[d]--;
                pops++;
            end
        @(posedge clk);
        #1;
        i_iter_done = 1'b0;
        drive_counts();
    endtask

    task automatic run(input int max_cyc, input bit bp, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            tick(1'b0, bp ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        i_iter_done = 1'b0;
        i_tx_ready = 1'b0;
        for (int d = 0; d < N; d++) cnt[d] = 0;
        drive_counts();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'(all_outs()), 64'(0));
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0);
            check("quiet_outputs", 64'(all_outs()), 64'(0));
        end

        // single full burst to dest 2, then pointer must favour 3 over 0
        cnt[2] = 8; drive_counts();
        push_pkt(2, 8);
        run(50, 1'b0, n);
        check("burst_cycles", 64'(n), 64'(10));
        check("burst_drained", 64'(cnt[2]), 64'(0));
        cnt[0] = 8; cnt[3] = 8; drive_counts();
        push_pkt(3, 8); push_pkt(0, 8);
        run(60, 1'b0, n);
        check("ptr_pair_cycles", 64'(n), 64'(20));

        // reset brings the pointer back to 0, then all buffers full
        rst = 1'b1; tick(1'b0, 1'b1); rst = 1'b0;
        for (int d = 0; d < N; d++) cnt[d] = 16;
        drive_counts();
        for (int p = 0; p < 8; p++) push_pkt(p % 4, 8);
        run(200, 1'b0, n);
        check("rr_cycles", 64'(n), 64'(80));
        check("rr_drained", 64'({8'(cnt[0]), 8'(cnt[1]), 8'(cnt[2]), 8'(cnt[3])}), 64'(0));

        // flush with partial buffers, a redundant pulse, and a re-arm on the done cycle
        cnt[1] = 3; cnt[3] = 5; drive_counts();
        push_pkt(1, 3); push_pkt(3, 5);
        cyc = 0; fd_q.delete();
        for (int c = 1; c <= 24; c++)
            tick(c == 1 || c == 5 || c == 15, 1'b1);
        check("flush_sb_empty", 64'(exp_q.size()), 64'(0));
        check("flush_pulses", 64'(fd_q.size()), 64'(2));
        if (fd_q.size() == 2) begin
            check("flush_first_cycle", 64'(fd_q[0]), 64'(15));
            check("flush_rearm_cycle", 64'(fd_q[1]), 64'(17));
        end
        check("flush_not_busy", 64'(o_busy), 64'(0));

        // back-pressure on a dest 0 packet
        cnt[0] = 8; drive_counts();
        push_pkt(0, 8);
        pops = 0;
        run(100, 1'b1, n);
        check("bp_pops", 64'(pops), 64'(8));
        check("bp_drained", 64'(cnt[0]), 64'(0));

        // reset in the middle of a packet
        cnt[0] = 8; drive_counts();
        push_pkt(0, 8);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        rst = 1'b1;
        tick(1'b0, 1'b1);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("post_rst_outputs", 64'(all_outs()), 64'(0));
        cnt[0] = 5; drive_counts();
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b1);
            check("below_burst_quiet", 64'(o_tx_valid), 64'(0));
        end
        check("below_burst_kept", 64'(cnt[0]), 64'(5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ring_pos_to_remote_scheduler.md
Name: ring_pos_to_remote_scheduler

Overview:
- Drains the per-destination remote position buffers into the single inter-FPGA TX stream, one packet at a time.
- Packet format: one header flit, then 1..BURST_LEN data flits popped from one first-word-fall-through (FWFT) buffer.
- Destinations are chosen round-robin among eligible buffers.
- An end-of-iteration flush sends partial packets, so every buffered position leaves the node before the iteration completes.

Parameters:
- NUM_REMOTE_DEST_NODES, 4, number of remote destination buffers (>=2).
- REMOTE_NODE_IDX_WIDTH, 2, equals $clog2(NUM_REMOTE_DEST_NODES).
- CNT_WIDTH, 8, width of each buffer occupancy count.
- BURST_LEN, 8, maximum data flits per packet (<= 2^CNT_WIDTH-1).
- LEN_WIDTH, 4, equals $clog2(BURST_LEN+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_iter_done  in  1  single-cycle pulse: position generation for this iteration has finished; start flush.
- i_buf_count  in  NUM_REMOTE_DEST_NODES*CNT_WIDTH  occupancy of each buffer; slice d is buffer d.
- o_buf_rd_en  out  NUM_REMOTE_DEST_NODES  one-hot pop strobe to the FWFT buffers.
- o_buf_sel  out  REMOTE_NODE_IDX_WIDTH  buffer index selected for the external data mux.
- o_tx_valid  out  1  TX flit valid.
- i_tx_ready  in  1  TX flit accepted when o_tx_valid & i_tx_ready.
- o_tx_is_header  out  1  current flit is a header (dest/len carried in header fields).
- o_tx_last  out  1  current flit is the final data flit of the packet.
- o_tx_dest  out  REMOTE_NODE_IDX_WIDTH  destination of the current packet.
- o_tx_len  out  LEN_WIDTH  data flit count of the current packet.
- o_busy  out  1  FSM not IDLE, or flush pending.
- o_flush_done  out  1  single-cycle pulse when the flush has completed.

Behaviour:
- Reset: FSM=IDLE, priority pointer=0, flush_pending=0, remaining=0. All outputs 0.
- Eligibility: req[d] = (count[d] >= BURST_LEN) | (flush_pending & count[d] != 0).
- Grant: the first d with req[d] set, scanning from the priority pointer upward with wrap-around.
- IDLE, any req set:
  - latch dest = granted d;
  - latch len = min(count[d], BURST_LEN);
  - next state HDR. The IDLE decision costs one cycle.
- HDR:
  - o_tx_valid=1, o_tx_is_header=1, o_tx_dest/o_tx_len driven from the latches.
  - Hold all outputs stable until i_tx_ready; on handshake go to DATA with remaining=len.
- DATA:
  - o_tx_valid=1, o_buf_sel=dest.
  - o_buf_rd_en[dest] = i_tx_ready, combinational, so exactly one pop per accepted flit.
  - o_tx_last = (remaining==1). remaining decrements on each handshake.
  - On the last handshake: priority pointer = dest+1 mod NUM_REMOTE_DEST_NODES; state = IDLE.
- Throughput: one flit per cycle when ready is held high. Minimum packet = 1 + len + 1 cycles, the last being the IDLE decision cycle.
- Count changes during a packet:
  - The latched len is never revised.
  - Count growth while a packet is in flight is seen only at the next IDLE decision.
  - The block is the only popper, so a latched len is always available.
- Flush:
  - i_iter_done sets flush_pending in any state, including mid-packet and during reset release+1.
  - In IDLE with flush_pending and every count==0: o_flush_done pulses for one cycle, flush_pending clears, and no packet is started that cycle.
  - A second i_iter_done while flush_pending is already set is absorbed (no extra o_flush_done).
  - i_iter_done in the same cycle as o_flush_done re-arms flush_pending.
- Back-pressure: o_tx_valid, once asserted, never drops before its handshake. No pop occurs without i_tx_ready.
- Reset mid-packet: immediate return to IDLE, any partial packet is abandoned, no pop in the reset cycle.

Test Plan:
- Reset with counts {0,0,0,0}, iter_done=0 -> all outputs 0, o_busy=0 for 20 cycles.
- count[2]=8, ready=1 -> header dest=2 len=8, then 8 data flits on consecutive cycles. o_buf_rd_en=4'b0100 on each data flit, o_tx_last only on the 8th. Priority pointer becomes 3.
- All counts=16, ready=1 -> packet order 0,1,2,3,0, every packet len=8.
- count[1]=3, count[3]=5, i_iter_done pulse:
  - packets: dest1 len3, then dest3 len5;
  - counts are then 0, so o_flush_done pulses exactly once, one cycle after the final IDLE evaluation.
- Back-pressure during a dest0 packet: i_tx_ready toggles 1,0,0,1,... -> the header is held stable while ready=0, o_buf_rd_en=0 on the ready=0 cycles, and the total pop count equals len.
- Assert rst on the 3rd data flit of a len-8 packet -> next cycle FSM IDLE, all outputs 0. After release with count[0]=5 still below BURST_LEN and no flush, no packet is sent.
